// File: rtl/ddr2_burst_master.sv
// ddr2_burst_master
// Turns single user commands (direction, word address, beat count) into one
// burst on a DDR2 controller local interface.  Writes stream beats from the
// wr_data port; reads return on rd_data one cycle after the controller
// presents them.  Only one command is in flight at a time.
//
// Handshake rules (all channels):
//   - cmd:     a command transfers on a rising edge where cmd_valid and
//              cmd_ready are both 1.  cmd_ready is a function of state only.
//   - wr_data: a beat transfers on a rising edge where wr_data_valid and
//              wr_data_ready are both 1 (wr_data_ready mirrors local_ready
//              while a write burst is open, so this equals a controller
//              write accept).
//   - local write/read request: accepted on a rising edge where the request
//              and local_ready are both 1.
//   - rd_data / local_rdata: valid-only streams, no backpressure; every
//              valid cycle is one beat.
// The FSM state and the active beat counter are exported on dbg_state and
// dbg_beat_cnt so checkers can observe progress without probing internals.

module ddr2_burst_master #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 32,
   parameter int SIZE_W = 7
) (
   input  logic                  phy_clk,
   input  logic                  phy_rst,

   // user command channel
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [SIZE_W-1:0]     cmd_len,

   // user write-data stream
   input  logic                  wr_data_valid,
   output logic                  wr_data_ready,
   input  logic [DATA_W-1:0]     wr_data,

   // user read-data stream
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_data_valid,

   // controller local interface
   output logic [ADDR_W-1:0]     local_address,
   output logic [SIZE_W-1:0]     local_size,
   output logic                  local_burstbegin,
   output logic                  local_write_req,
   output logic                  local_read_req,
   output logic [DATA_W-1:0]     local_wdata,
   output logic [DATA_W/8-1:0]   local_be,
   input  logic                  local_ready,
   input  logic                  local_init_done,
   input  logic                  local_rdata_valid,
   input  logic [DATA_W-1:0]     local_rdata,

   // status
   output logic                  busy,
   output logic                  cmd_err,

   // observability
   output logic [2:0]            dbg_state,
   output logic [SIZE_W-1:0]     dbg_beat_cnt
);

   // Longest legal burst; counters only ever reach this value, never wrap.
   localparam logic [SIZE_W-1:0] MAX_LEN  = SIZE_W'(64);
   localparam logic [SIZE_W-1:0] ONE_BEAT = SIZE_W'(1);

   typedef enum logic [2:0] {
      INIT     = 3'd0,
      IDLE     = 3'd1,
      WR_BURST = 3'd2,
      RD_REQ   = 3'd3,
      RD_WAIT  = 3'd4
   } state_t;

   state_t              state_q;
   state_t              state_d;

   // command latched at the handshake, held for the whole burst
   logic [ADDR_W-1:0]   addr_q;
   logic [SIZE_W-1:0]   len_q;
   logic                wr_q;

   // beats accepted by the controller / beats received from it
   logic [SIZE_W-1:0]   wr_cnt_q;
   logic [SIZE_W-1:0]   rd_cnt_q;

   // read return pipeline and error pulse
   logic [DATA_W-1:0]   rd_data_q;
   logic                rd_valid_q;
   logic                cmd_err_q;

   logic                cmd_hs;
   logic                len_ok;
   logic                wr_accept;
   logic                wr_last;
   logic                in_read;
   logic                rd_beat;
   logic                rd_done;

   // Decode of the current cycle's transfers.
   assign cmd_hs    = cmd_valid && cmd_ready;
   assign len_ok    = (cmd_len != '0) && (cmd_len <= MAX_LEN);
   assign wr_accept = local_write_req && local_ready;
   assign wr_last   = wr_accept && ((wr_cnt_q + ONE_BEAT) == len_q);
   // A beat can arrive in the same cycle the read request is accepted, so
   // RD_REQ counts too.  Beats beyond len are ignored to keep the count bounded.
   assign in_read   = (state_q == RD_REQ) || (state_q == RD_WAIT);
   assign rd_beat   = in_read && local_rdata_valid && (rd_cnt_q != len_q);
   assign rd_done   = (rd_cnt_q == len_q) ||
                      (rd_beat && ((rd_cnt_q + ONE_BEAT) == len_q));

   // State register.
   always_ff @(posedge phy_clk) begin
      if (phy_rst) begin
         state_q <= INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; losing init_done overrides every other transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT: begin
            if (local_init_done) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (cmd_hs && len_ok) begin
               state_d = cmd_wr ? WR_BURST : RD_REQ;
            end
         end
         WR_BURST: begin
            if (wr_last) begin
               state_d = IDLE;
            end
         end
         RD_REQ: begin
            if (local_ready) begin
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (rd_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase
      if (!local_init_done) begin
         state_d = INIT;
      end
   end

   // Command latch, beat counters, read return pipeline and error pulse.
   always_ff @(posedge phy_clk) begin
      if (phy_rst) begin
         addr_q     <= '0;
         len_q      <= '0;
         wr_q       <= 1'b0;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         // read data is forwarded in every state so no beat is ever lost
         rd_data_q  <= local_rdata;
         rd_valid_q <= local_rdata_valid;
         cmd_err_q  <= cmd_hs && !len_ok;
         if (!local_init_done) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
         end else if (cmd_hs) begin
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            wr_q     <= cmd_wr;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
         end else begin
            if (wr_accept) begin
               wr_cnt_q <= wr_cnt_q + ONE_BEAT;
            end
            if (rd_beat) begin
               rd_cnt_q <= rd_cnt_q + ONE_BEAT;
            end
         end
      end
   end

   // Outputs decoded from state; reset forces every request and ready low.
   always_comb begin
      cmd_ready        = 1'b0;
      wr_data_ready    = 1'b0;
      local_burstbegin = 1'b0;
      local_write_req  = 1'b0;
      local_read_req   = 1'b0;
      local_wdata      = '0;
      local_be         = '0;
      busy             = 1'b1;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         WR_BURST: begin
            local_write_req  = wr_data_valid;
            wr_data_ready    = local_ready;
            local_wdata      = wr_data;
            local_be         = '1;
            // burstbegin marks the first beat only and stays up until taken
            local_burstbegin = wr_data_valid && (wr_cnt_q == '0);
         end
         RD_REQ: begin
            local_read_req   = 1'b1;
            local_burstbegin = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
      if (phy_rst) begin
         cmd_ready        = 1'b0;
         wr_data_ready    = 1'b0;
         local_burstbegin = 1'b0;
         local_write_req  = 1'b0;
         local_read_req   = 1'b0;
         busy             = 1'b1;
      end
   end

   assign local_address = addr_q;
   assign local_size    = len_q;
   assign rd_data       = rd_data_q;
   assign rd_data_valid = rd_valid_q && !phy_rst;
   assign cmd_err       = cmd_err_q && !phy_rst;
   assign dbg_state     = state_q;
   assign dbg_beat_cnt  = wr_q ? wr_cnt_q : rd_cnt_q;

endmodule
